// File: rtl/dvi_tx_timing_ctrl_if.sv
// rtl/dvi_tx_timing_ctrl_if.sv - pixel source handshake and TMDS-side timing bundle
interface dvi_tx_timing_ctrl_if;
    logic        pix_req;
    logic        pix_valid;
    logic [23:0] pix_in;
    logic        den;
    logic        hsync;
    logic        vsync;
    logic [23:0] pixel_data;
    logic        frame_start;
    logic        line_start;

    modport master (
        output pix_req,
        input  pix_valid,
        input  pix_in,
        output den,
        output hsync,
        output vsync,
        output pixel_data,
        output frame_start,
        output line_start
    );

    modport slave (
        input  pix_req,
        output pix_valid,
        output pix_in,
        input  den,
        input  hsync,
        input  vsync,
        input  pixel_data,
        input  frame_start,
        input  line_start
    );
endinterface

// File: rtl/dvi_tx_timing_ctrl.sv
// rtl/dvi_tx_timing_ctrl.sv - DVI raster timing generator with pixel fetch and underflow flag
module dvi_tx_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned H_FP     = 88,
    parameter int unsigned H_SYNC   = 44,
    parameter int unsigned H_BP     = 148,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned V_FP     = 4,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 36,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic                        pixel_clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        underflow_clr,
    output logic                        underflow,
    output logic                        running,
    dvi_tx_timing_ctrl_if.master        vif
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [HW-1:0]   r_h_cnt;
    logic [VW-1:0]   r_v_cnt;
    logic [31:0]     w_h_ext;
    logic [31:0]     w_v_ext;
    logic            w_live;
    logic            w_h_last;
    logic            w_v_last;
    logic            w_active;
    logic            w_hs_zone;
    logic            w_vs_zone;

    logic            r_den;
    logic            r_hsync;
    logic            r_vsync;
    logic [23:0]     r_pixel_data;
    logic            r_frame_start;
    logic            r_line_start;
    logic            r_underflow;
    logic            r_running;

    assign w_h_ext   = 32'(r_h_cnt);
    assign w_v_ext   = 32'(r_v_cnt);
    assign w_live    = (r_state != S_IDLE);
    assign w_h_last  = (w_h_ext == H_TOTAL - 1);
    assign w_v_last  = (w_v_ext == V_TOTAL - 1);
    assign w_active  = w_live && (w_h_ext < H_ACTIVE) && (w_v_ext < V_ACTIVE);
    assign w_hs_zone = w_live && (w_h_ext >= H_ACTIVE + H_FP)
                              && (w_h_ext <  H_ACTIVE + H_FP + H_SYNC);
    assign w_vs_zone = w_live && (w_v_ext >= V_ACTIVE + V_FP)
                              && (w_v_ext <  V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A drained frame always runs to its last pixel; re-enabling cancels the drain.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (enable) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!enable) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (enable) begin
                    w_state_nxt = S_RUN;
                end else if (w_h_last && w_v_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!w_live) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    // Every timing output is the counter position of the previous cycle.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_den         <= 1'b0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_pixel_data  <= 24'h000000;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_underflow   <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            r_den         <= w_active;
            r_hsync       <= w_hs_zone ? HS_POL : ~HS_POL;
            r_vsync       <= w_vs_zone ? VS_POL : ~VS_POL;
            r_pixel_data  <= (w_active && vif.pix_valid) ? vif.pix_in : 24'h000000;
            r_frame_start <= w_live && (r_h_cnt == '0) && (r_v_cnt == '0);
            r_line_start  <= w_live && (r_h_cnt == '0) && (w_v_ext < V_ACTIVE);
            r_running     <= w_live;
            if (w_active && !vif.pix_valid) begin
                r_underflow <= 1'b1;
            end else if (underflow_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign vif.pix_req     = w_active;
    assign vif.den         = r_den;
    assign vif.hsync       = r_hsync;
    assign vif.vsync       = r_vsync;
    assign vif.pixel_data  = r_pixel_data;
    assign vif.frame_start = r_frame_start;
    assign vif.line_start  = r_line_start;
    assign underflow       = r_underflow;
    assign running         = r_running;
endmodule

// File: tb/tb_dvi_tx_timing_ctrl.sv
// tb/tb_dvi_tx_timing_ctrl.sv - directed bench for dvi_tx_timing_ctrl on an 8x6 raster
module tb_dvi_tx_timing_ctrl;
    logic pixel_clock = 1'b0;
    logic reset_n;
    logic enable;
    logic underflow_clr;
    logic underflow;
    logic running;
    int   n_pass  = 0;
    int   n_total = 0;
    int   pix_cnt = 0;
    int   cur_k   = -1;

    dvi_tx_timing_ctrl_if vif();

    dvi_tx_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .pixel_clock   (pixel_clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .underflow_clr (underflow_clr),
        .underflow     (underflow),
        .running       (running),
        .vif           (vif)
    );

    always #5 pixel_clock = ~pixel_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s pos=%0d observed=%0h expected=%0h", tag, cur_k, obs, exp);
    endtask

    // One raster position k (h = k%8, v = k/8): check pix_req, drive a pixel, check the outputs.
    task automatic cycle(input int k, input logic live, input logic exp_run, input logic valid);
        int          h;
        int          v;
        logic        e_den;
        logic [23:0] px;
        h     = k % 8;
        v     = k / 8;
        cur_k = k;
        e_den = live && (h < 4) && (v < 3);
        chk("pix_req", vif.pix_req, e_den);
        px = 24'(pix_cnt * 32'h0001_0307 + 32'h00A5_5A00);
        pix_cnt++;
        vif.pix_in    = px;
        vif.pix_valid = valid;
        @(negedge pixel_clock);
        chk("den",         vif.den,         e_den);
        chk("hsync",       vif.hsync,       live && (h == 5 || h == 6));
        chk("vsync",       vif.vsync,       live && (v == 4));
        chk("frame_start", vif.frame_start, live && (k == 0));
        chk("line_start",  vif.line_start,  live && (h == 0) && (v < 3));
        chk("pixel_data",  vif.pixel_data,  (e_den && valid) ? px : 24'h0);
        chk("running",     running,         exp_run);
        chk("den_hs_overlap", vif.den & vif.hsync, 1'b0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_den"},     vif.den,         1'b0);
        chk({tag, "_hsync"},   vif.hsync,       1'b0);
        chk({tag, "_vsync"},   vif.vsync,       1'b0);
        chk({tag, "_pixel"},   vif.pixel_data,  24'h0);
        chk({tag, "_fs"},      vif.frame_start, 1'b0);
        chk({tag, "_ls"},      vif.line_start,  1'b0);
        chk({tag, "_uflow"},   underflow,       1'b0);
        chk({tag, "_running"}, running,         1'b0);
        chk({tag, "_pix_req"}, vif.pix_req,     1'b0);
    endtask

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b0;
        underflow_clr = 1'b0;
        vif.pix_valid = 1'b0;
        vif.pix_in    = 24'h0;
        @(negedge pixel_clock);
        @(negedge pixel_clock);
        chk_idle_outputs("reset");
        reset_n = 1'b1;
        @(negedge pixel_clock);
        chk_idle_outputs("idle");

        // Two full frames with continuous enable and valid source
        enable = 1'b1;
        @(negedge pixel_clock);
        chk("start_running", running, 1'b0);
        for (int k = 0; k < 96; k++) cycle(k % 48, 1'b1, 1'b1, 1'b1);

        // Drop enable at (1,1): drain to (7,5), then idle
        for (int k = 0; k < 9; k++) cycle(k, 1'b1, 1'b1, 1'b1);
        enable = 1'b0;
        for (int k = 9; k < 48; k++) cycle(k, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) cycle(0, 1'b0, 1'b0, 1'b1);
        chk("drain_idle_uflow", underflow, 1'b0);

        // Underflow at (2,0), clear-vs-set priority, then clear alone
        enable = 1'b1;
        @(negedge pixel_clock);
        cycle(0, 1'b1, 1'b1, 1'b1);
        cycle(1, 1'b1, 1'b1, 1'b1);
        chk("uflow_before", underflow, 1'b0);
        cycle(2, 1'b1, 1'b1, 1'b0);
        chk("uflow_set", underflow, 1'b1);
        underflow_clr = 1'b1;
        cycle(3, 1'b1, 1'b1, 1'b0);
        chk("uflow_set_wins", underflow, 1'b1);
        underflow_clr = 1'b0;
        cycle(4, 1'b1, 1'b1, 1'b1);
        chk("uflow_sticky", underflow, 1'b1);
        underflow_clr = 1'b1;
        cycle(5, 1'b1, 1'b1, 1'b1);
        chk("uflow_cleared", underflow, 1'b0);
        underflow_clr = 1'b0;
        for (int k = 6; k < 18; k++) cycle(k, 1'b1, 1'b1, 1'b1);
        cycle(18, 1'b1, 1'b1, 1'b0);
        chk("uflow_reset_pre", underflow, 1'b1);

        // Asynchronous reset with the counter at (3,2)
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        @(negedge pixel_clock);
        reset_n = 1'b1;
        cycle(0, 1'b0, 1'b0, 1'b1);
        cycle(0, 1'b0, 1'b0, 1'b1);

        // Restart from (0,0); enable toggles low/high inside one frame
        enable = 1'b1;
        @(negedge pixel_clock);
        for (int k = 0; k < 48; k++) begin
            enable = !(k >= 10 && k < 15);
            cycle(k, 1'b1, 1'b1, 1'b1);
        end
        enable = 1'b1;
        for (int k = 0; k < 48; k++) cycle(k, 1'b1, 1'b1, 1'b1);
        enable = 1'b0;
        for (int k = 0; k < 48; k++) cycle(k, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) cycle(0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dvi_tx_timing_ctrl.md
DVI_TX_TIMING_CTRL -- requirements
Module: dvi_tx_timing_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 1920, active pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 88 / 44 / 148, horizontal front porch / sync / back porch in pixels.
REQ-003 Parameter V_ACTIVE, default 1080, active lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 4 / 5 / 36, vertical front porch / sync / back porch in lines.
REQ-005 Parameter HS_POL / VS_POL, default 1 / 1, active level of hsync / vsync.
REQ-006 pixel_clock  in  1  sole clock, all logic on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 enable  in  1  level request to run video timing.
REQ-009 pix_req  out  1  combinational; high when the current counter position is active.
REQ-010 pix_valid  in  1  source has a pixel for this cycle; sampled only while pix_req high.
REQ-011 pix_in  in  24  source pixel, {R,G,B}.
REQ-012 den / hsync / vsync  out  1 each  registered timing outputs to the TMDS transmitter.
REQ-013 pixel_data  out  24  registered pixel, aligned with den.
REQ-014 frame_start / line_start  out  1 each  registered one-cycle pulses.
REQ-015 underflow  out  1  sticky flag; underflow_clr  in  1  clears it.
REQ-016 running  out  1  high in RUN or DRAIN.

Function
REQ-017 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; counter widths = clog2(total), no overflow possible.
REQ-018 States IDLE, RUN, DRAIN; IDLE holds h_cnt = v_cnt = 0, pix_req low.
REQ-019 IDLE -> RUN on the edge enable is sampled high; counting starts at (0,0) on the following cycle.
REQ-020 RUN/DRAIN: h_cnt increments each cycle, wraps H_TOTAL-1 -> 0; v_cnt increments on h wrap, wraps V_TOTAL-1 -> 0.
REQ-021 RUN -> DRAIN when enable sampled low; DRAIN -> RUN when enable sampled high again (no counter disturbance).
REQ-022 DRAIN -> IDLE on the cycle at (H_TOTAL-1, V_TOTAL-1); frames are never truncated.
REQ-023 Active = h_cnt < H_ACTIVE and v_cnt < V_ACTIVE, only in RUN/DRAIN.
REQ-024 hsync asserted (HS_POL) when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else inactive.
REQ-025 vsync asserted (VS_POL) for all h_cnt when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else inactive.
REQ-026 den, hsync, vsync, pixel_data, frame_start, line_start are registered: one cycle latency from counter position.
REQ-027 pixel_data = pix_in when active and pix_valid; 24'h000000 otherwise.
REQ-028 Active and pix_valid low: underflow set; den still asserted, timing never stalls.
REQ-029 underflow_clr clears underflow; simultaneous set and clear: set wins.
REQ-030 frame_start high for the output cycle of position (0,0); line_start high for each output cycle at h_cnt = 0 with v_cnt < V_ACTIVE.
REQ-031 In IDLE all timing outputs at inactive levels; running low one cycle after IDLE entry.

Reset
REQ-032 reset_n low asynchronously forces: state IDLE, counters 0, den 0, hsync = ~HS_POL, vsync = ~VS_POL, pixel_data 0, frame_start 0, line_start 0, underflow 0, running 0.
REQ-033 Reset mid-frame abandons the frame; after release, restart only via REQ-019 and always from (0,0).

Verification (H 4/1/2/1 -> H_TOTAL 8; V 3/1/1/1 -> V_TOTAL 6; pols 1)
REQ-034 enable=1 held, pix_valid=1, pix_in = count -> den high 4 of every 8 cycles on lines 0-2, 48-cycle frame, frame_start every 48 cycles, pixel_data equals pix_in of previous cycle.
REQ-035 Same run -> hsync high output cycles h=5,6 each line; vsync high all 8 cycles of line 4; den never overlaps hsync.
REQ-036 enable dropped at (1,1) -> running stays high until (7,5) is output, no further den, then all outputs inactive and IDLE.
REQ-037 pix_valid=0 at (2,0) -> den=1 with pixel_data 0 next cycle, underflow=1 sticky; underflow_clr with simultaneous underflow -> stays 1; clr alone -> 0.
REQ-038 reset_n low at (3,2) -> outputs at REQ-032 values immediately; enable=1 after release -> first den at position (0,0), frame_start asserted with it.
REQ-039 enable toggled low then high within one DRAIN frame -> returns to RUN, no gap in den/sync cadence.
